// File: rtl/relu.sv
// Vector ReLU stage: on start, registers max(x, 0) for every element of a signed
// fixed-point vector and raises done for one cycle per accepted vector.
module relu #(
    parameter int NUM_CLASSES   = 4,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic signed [FP_TOTAL_BITS-1:0] input_vector [NUM_CLASSES],
    output logic signed [FP_TOTAL_BITS-1:0] relu_out     [NUM_CLASSES],
    output logic                            done
);

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [FP_TOTAL_BITS-1:0] relu_q [NUM_CLASSES];
    logic signed [FP_TOTAL_BITS-1:0] relu_d [NUM_CLASSES];

    // Q format is irrelevant to rectification; only the sign bit matters.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            relu_d[i] = input_vector[i][FP_TOTAL_BITS-1] ? '0 : input_vector[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                relu_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start) begin
                for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                    relu_q[i] <= relu_d[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? DONE : IDLE;
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done decodes the state register only, so no input reaches an output combinationally.
    always_comb begin
        done = (state_q == DONE);
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            relu_out[i] = relu_q[i];
        end
    end

endmodule

// File: tb/tb_relu.sv
// Scoreboard bench for relu: stimulus pushes expected vectors, a monitor pops
// and compares them whenever done is observed.
module tb_relu;

    localparam int N = 4;
    localparam int W = 16;
    localparam int F = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [W-1:0] input_vector [N];
    logic signed [W-1:0] relu_out     [N];
    logic                done;

    logic [N*W-1:0] exp_q [$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    relu #(
        .NUM_CLASSES  (N),
        .FP_TOTAL_BITS(W),
        .FP_FRAC_BITS (F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .input_vector(input_vector),
        .relu_out    (relu_out),
        .done        (done)
    );

    function automatic logic [N*W-1:0] mk(input int a, input int b, input int c, input int d);
        logic [W-1:0] ea, eb, ec, ed;
        ea = W'(a); eb = W'(b); ec = W'(c); ed = W'(d);
        return {ed, ec, eb, ea};
    endfunction

    // Reference: each element is max(x, 0) as a signed integer.
    function automatic logic [N*W-1:0] model(input logic [N*W-1:0] v);
        logic [N*W-1:0] r;
        int x;
        for (int i = 0; i < N; i++) begin
            x = int'($signed(v[i*W +: W]));
            r[i*W +: W] = (x < 0) ? W'(0) : W'(x);
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack_out();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = relu_out[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N*W-1:0] v);
        for (int i = 0; i < N; i++) input_vector[i] = v[i*W +: W];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [N*W-1:0] v);
        drive(v);
        start = 1'b1;
        exp_q.push_back(model(v));
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every observed done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected done=0 data %h", pack_out());
            end else begin
                check("result", pack_out(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] held;
        logic [N*W-1:0] v;
        int wait_cnt;

        reset = 1'b1;
        start = 1'b0;
        drive('0);
        tick();
        tick();
        reset = 1'b0;
        check("reset_out", pack_out(), '0);
        check("reset_done", {{(N*W-1){1'b0}}, done}, '0);

        // Hand vector, then hold for 5 cycles.
        issue(mk(128, -256, 0, 768));
        held = mk(128, 0, 0, 768);
        drive(mk(-1, 1, -1, 1));
        repeat (5) tick();
        check("hand_hold", pack_out(), held);
        check("hand_done_low", {{(N*W-1){1'b0}}, done}, '0);

        // Extremes.
        issue(mk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001));
        tick();
        check("extreme_hold", pack_out(), mk(0, 16'h7FFF, 0, 1));

        // Random vectors, each followed by a reset pulse.
        for (int k = 0; k < 20; k++) begin
            v = mk(int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255,
                   int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255);
            issue(v);
            pulse_reset();
            check("rand_reset_out", pack_out(), '0);
        end

        // Back-to-back starts, then an input change with start low.
        drive(mk(-5, 5, -6, 6));
        exp_q.push_back(model(mk(-5, 5, -6, 6)));
        start = 1'b1;
        tick();
        drive(mk(7, -7, 8, -8));
        exp_q.push_back(model(mk(7, -7, 8, -8)));
        tick();
        start = 1'b0;
        drive(mk(1000, 1000, 1000, 1000));
        repeat (3) tick();
        check("b2b_hold", pack_out(), mk(7, 0, 8, 0));

        // Reset while in DONE, with a concurrent start that must be dropped.
        issue(mk(50, 60, 70, 80));
        reset = 1'b1;
        start = 1'b1;
        drive(mk(100, 100, 100, 100));
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio_out", pack_out(), '0);
        check("rst_prio_done", {{(N*W-1){1'b0}}, done}, '0);
        tick();
        check("rst_prio_hold", pack_out(), '0);

        // Drain: all expected results must have been observed.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("drain", {{(N*W-32){1'b0}}, 32'(exp_q.size())}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
